quad_encoder_capture: RTL and testbench

Avalon-MM slave that decodes the servo motor's quadrature encoder (A/B) into a 32-bit position. On each periodic sample pulse (the interval timer's timeout pulse, wired to sample_tick), it latches a position snapshot and a saturated 16-bit velocity. It then raises irq to the Nios control loop. It sits between the encoder pins and the CPU, downstream of the interval timer.

---
 rtl/qenc_pkg.sv | 34 +++
 rtl/quad_encoder_capture_if.sv | 14 +
 rtl/qenc_input_filter.sv | 63 ++++++
 rtl/quad_encoder_capture.sv | 147 ++++++++++++++
 tb/tb_quad_encoder_capture.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/qenc_pkg.sv
// Shared constants for the quadrature encoder capture block: register map,
// status/control bit positions and the forward Gray-code sequence.
package qenc_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_POS_LO   = 3'd2;
  localparam logic [2:0] ADDR_POS_HI   = 3'd3;
  localparam logic [2:0] ADDR_VELOCITY = 3'd4;
  localparam logic [2:0] ADDR_ERRCNT   = 3'd5;

  localparam int ST_SAMPLE_VALID = 0;
  localparam int ST_ERROR        = 1;

  localparam int CTL_IRQ_EN     = 0;
  localparam int CTL_COUNT_EN   = 1;
  localparam int CTL_DIR_INVERT = 2;
  localparam int CTL_POS_CLR    = 3;

  // {A,B} in forward order: 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [7:0] GRAY_FWD_SEQ = 8'b00_01_11_10;

  // Position of an {A,B} pair within the forward sequence; the difference of
  // two indices (mod 4) gives the step: 1 = forward, 3 = reverse, 2 = illegal.
  function automatic logic [1:0] gray_index(input logic [1:0] ab);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (GRAY_FWD_SEQ[7-2*i -: 2] == ab) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/quad_encoder_capture_if.sv
// Avalon-MM slave bus plus interrupt line of the encoder capture block.
interface quad_encoder_capture_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/qenc_input_filter.sv
// Synchronizer plus stability filter for one asynchronous encoder channel.
// vld_o rises once the synced input has first been seen stable for
// FILTER_LEN cycles, so the decoder never primes on the reset value alone.
module qenc_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic filt_o,
  output logic vld_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q, filt_d;
  logic                   vld_q, vld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;
  assign vld_o  = vld_q;

  // Shift the raw pin through the metastability chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  // Accept a new level only after FILTER_LEN consecutive differing cycles;
  // before the first acceptance filt_q is just the candidate being timed
  always_comb begin
    filt_d = filt_q;
    vld_d  = vld_q;
    cnt_d  = '0;
    if (!vld_q) begin
      if (synced != filt_q)      filt_d = synced;
      else if (cnt_q == CNT_LAST) vld_d = 1'b1;
      else                       cnt_d = cnt_q + 1'b1;
    end else if (synced != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = synced;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  // Filter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_encoder_capture.sv
// Quadrature encoder capture: decodes filtered A/B into a 32-bit position,
// snapshots position and saturated velocity on sample_tick, and exposes
// everything through a small Avalon-MM register file with a level irq.
module quad_encoder_capture
  import qenc_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILTER_LEN  = 4,
  parameter logic [31:0] POS_RESET   = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  quad_encoder_capture_if.slave        bus,
  input  logic                         enc_a,
  input  logic                         enc_b,
  input  logic                         sample_tick
);

  logic              filt_a, filt_b, vld_a, vld_b;
  logic [1:0]        cur_ab, prev_q, prev_d;
  logic              primed_q, primed_d;
  logic [1:0]        delta;
  logic              step_fwd, step_rev, illegal, step_up;
  logic              wr, wr_status, wr_ctrl, pos_clr;
  logic [31:0]       pos_q, pos_d, snap_q, snap_d, ref_q, ref_d;
  logic signed [32:0] diff;
  logic signed [15:0] vel_q, vel_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              sv_q, sv_d, err_q, err_d;
  logic [7:0]        errcnt_q, errcnt_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              unused_wdata;

  qenc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset_n(reset_n), .in_i(enc_a), .filt_o(filt_a), .vld_o(vld_a));
  qenc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset_n(reset_n), .in_i(enc_b), .filt_o(filt_b), .vld_o(vld_b));

  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)       return 16'sh7FFF;
    else if (v < -33'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  assign cur_ab       = {filt_a, filt_b};
  assign wr           = bus.chipselect & ~bus.write_n;
  assign wr_status    = wr && (bus.address == ADDR_STATUS);
  assign wr_ctrl      = wr && (bus.address == ADDR_CONTROL);
  assign pos_clr      = wr_ctrl & bus.writedata[CTL_POS_CLR];
  assign unused_wdata = ^bus.writedata[15:4];
  assign bus.irq      = sv_q & ctrl_q[CTL_IRQ_EN];
  assign bus.readdata = rdata_q;

  // Classify the filtered A/B transition; nothing counts until primed
  always_comb begin
    delta    = gray_index(cur_ab) - gray_index(prev_q);
    step_fwd = 1'b0;
    step_rev = 1'b0;
    illegal  = 1'b0;
    if (primed_q) begin
      case (delta)
        2'd1:    step_fwd = 1'b1;
        2'd3:    step_rev = 1'b1;
        2'd2:    illegal  = 1'b1;
        default: ;
      endcase
    end
    step_up = step_fwd ^ ctrl_q[CTL_DIR_INVERT];
  end

  // Next state of position, snapshot, velocity, status and register file
  always_comb begin
    prev_d   = cur_ab;
    primed_d = primed_q | (vld_a & vld_b);

    pos_d = pos_q;
    if (ctrl_q[CTL_COUNT_EN] && (step_fwd || step_rev))
      pos_d = step_up ? pos_q + 32'd1 : pos_q - 32'd1;
    if (pos_clr) pos_d = '0;

    diff   = $signed({pos_q[31], pos_q}) - $signed({ref_q[31], ref_q});
    snap_d = snap_q;
    vel_d  = vel_q;
    ref_d  = ref_q;
    if (sample_tick) begin
      snap_d = pos_q;
      vel_d  = sat16(diff);
      ref_d  = pos_q;
    end
    if (pos_clr) ref_d = '0;

    sv_d  = sv_q;
    err_d = err_q;
    if (wr_status) begin
      sv_d  = 1'b0;
      err_d = 1'b0;
    end
    if (sample_tick) sv_d  = 1'b1;
    if (illegal)     err_d = 1'b1;

    errcnt_d = errcnt_q;
    if (illegal && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;

    ctrl_d = ctrl_q;
    if (wr_ctrl) ctrl_d = bus.writedata[2:0];

    case (bus.address)
      ADDR_STATUS:   rdata_d = {14'd0, err_q, sv_q};
      ADDR_CONTROL:  rdata_d = {13'd0, ctrl_q};
      ADDR_POS_LO:   rdata_d = snap_q[15:0];
      ADDR_POS_HI:   rdata_d = snap_q[31:16];
      ADDR_VELOCITY: rdata_d = $unsigned(vel_q);
      ADDR_ERRCNT:   rdata_d = {8'd0, errcnt_q};
      default:       rdata_d = 16'd0;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      pos_q    <= POS_RESET;
      snap_q   <= '0;
      vel_q    <= '0;
      ref_q    <= '0;
      ctrl_q   <= '0;
      sv_q     <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
      rdata_q  <= '0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      pos_q    <= pos_d;
      snap_q   <= snap_d;
      vel_q    <= vel_d;
      ref_q    <= ref_d;
      ctrl_q   <= ctrl_d;
      sv_q     <= sv_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_quad_encoder_capture.sv
// Directed bench for quad_encoder_capture (SYNC_STAGES=2, FILTER_LEN=4).
module tb_quad_encoder_capture;
  import qenc_pkg::*;

  localparam int FLEN = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;
  logic sample_tick = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int enc_idx  = 0;
  logic [1:0]  seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [15:0] rd;

  always #5 clk = ~clk;

  quad_encoder_capture_if bus ();

  quad_encoder_capture #(.SYNC_STAGES(2), .FILTER_LEN(FLEN), .POS_RESET(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .enc_a(enc_a), .enc_b(enc_b), .sample_tick(sample_tick));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    @(posedge clk);
    #1 d = bus.readdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus_read(a, v);
    check(tag, {16'd0, v}, {16'd0, exp});
  endtask

  task automatic tick();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  task automatic steps(input int n, input int dir, input int hold);
    for (int i = 0; i < n; i++) begin
      enc_idx = (enc_idx + dir + 4) % 4;
      @(negedge clk);
      {enc_a, enc_b} = seq[enc_idx];
      repeat (hold - 1) @(negedge clk);
    end
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

    // reset state
    repeat (4) @(negedge clk);
    check("rst_readdata", {16'd0, bus.readdata}, 32'h0);
    check("rst_irq", {31'd0, bus.irq}, 32'h0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    for (int a = 0; a < 8; a++) read_check($sformatf("rst_reg%0d", a), 3'(a), 16'h0);

    // 1: ten forward steps
    bus_write(ADDR_CONTROL, 16'h0003);
    read_check("ctrl_rd", ADDR_CONTROL, 16'h0003);
    steps(10, 1, 8);
    repeat (12) @(negedge clk);
    tick();
    read_check("t1_pos_lo", ADDR_POS_LO, 16'h000A);
    read_check("t1_pos_hi", ADDR_POS_HI, 16'h0000);
    read_check("t1_vel", ADDR_VELOCITY, 16'h000A);
    read_check("t1_status", ADDR_STATUS, 16'h0001);
    check("t1_irq", {31'd0, bus.irq}, 32'h1);
    bus_write(ADDR_STATUS, 16'h0000);
    check("t1_irq_clr", {31'd0, bus.irq}, 32'h0);
    read_check("t1_status_clr", ADDR_STATUS, 16'h0000);

    // 2: reverse steps, then direction invert
    steps(3, -1, 8);
    repeat (12) @(negedge clk);
    tick();
    read_check("t2_pos_lo", ADDR_POS_LO, 16'h0007);
    read_check("t2_vel", ADDR_VELOCITY, 16'hFFFD);
    bus_write(ADDR_CONTROL, 16'h0007);
    steps(2, 1, 8);
    repeat (12) @(negedge clk);
    tick();
    read_check("t2_inv_pos_lo", ADDR_POS_LO, 16'h0005);
    read_check("t2_inv_vel", ADDR_VELOCITY, 16'hFFFE);

    // 3: glitch rejection and accepted-pulse latency (encoder at 01)
    bus_write(ADDR_CONTROL, 16'h0003);
    bus_write(ADDR_STATUS, 16'h0000);
    @(negedge clk); enc_a = 1'b1;
    repeat (FLEN - 1) @(negedge clk);
    enc_a = 1'b0;
    repeat (20) @(negedge clk);
    tick();
    read_check("t3_glitch_status", ADDR_STATUS, 16'h0001);
    read_check("t3_glitch_pos", ADDR_POS_LO, 16'h0005);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus.address = ADDR_POS_LO;
      enc_a = (c <= FLEN + 2);
      sample_tick = (c == 7 || c == 8);
      @(posedge clk);
      #1;
      if (c == 8) check("t3_pre_count", {16'd0, bus.readdata}, 32'h5);
      if (c == 9) check("t3_at_count", {16'd0, bus.readdata}, 32'h6);
    end
    @(negedge clk); sample_tick = 1'b0;
    repeat (10) @(negedge clk);
    tick();
    read_check("t3_pulse_back", ADDR_POS_LO, 16'h0005);
    read_check("t3_errcnt", ADDR_ERRCNT, 16'h0000);

    // 4: illegal double change from 00
    steps(1, -1, 8);
    repeat (12) @(negedge clk);
    bus_write(ADDR_STATUS, 16'h0000);
    @(negedge clk); enc_a = 1'b1; enc_b = 1'b1; enc_idx = 2;
    repeat (20) @(negedge clk);
    read_check("t4_status", ADDR_STATUS, 16'h0002);
    read_check("t4_errcnt", ADDR_ERRCNT, 16'h0001);
    check("t4_irq", {31'd0, bus.irq}, 32'h0);
    tick();
    read_check("t4_pos", ADDR_POS_LO, 16'h0004);

    // 5: velocity saturation, then clear together with tick
    steps(33000, 1, 2);
    repeat (12) @(negedge clk);
    tick();
    read_check("t5_pos_lo", ADDR_POS_LO, 16'h80EC);
    read_check("t5_pos_hi", ADDR_POS_HI, 16'h0000);
    read_check("t5_vel_sat", ADDR_VELOCITY, 16'h7FFF);
    @(negedge clk);
    bus.address = ADDR_CONTROL; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    bus.writedata = 16'h000B; sample_tick = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; sample_tick = 1'b0;
    read_check("t5_clr_snap", ADDR_POS_LO, 16'h80EC);
    read_check("t5_clr_vel", ADDR_VELOCITY, 16'h0000);
    read_check("t5_ctrl_bit3", ADDR_CONTROL, 16'h0003);
    tick();
    read_check("t5_after_lo", ADDR_POS_LO, 16'h0000);
    read_check("t5_after_hi", ADDR_POS_HI, 16'h0000);
    read_check("t5_after_vel", ADDR_VELOCITY, 16'h0000);

    // 6: async reset mid-step, encoder left at 11
    @(negedge clk); enc_a = 1'b1; enc_b = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_readdata", {16'd0, bus.readdata}, 32'h0);
    check("t6_rst_irq", {31'd0, bus.irq}, 32'h0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    for (int a = 0; a < 6; a++) read_check($sformatf("t6_reg%0d", a), 3'(a), 16'h0);
    bus_write(ADDR_CONTROL, 16'h0003);
    repeat (10) @(negedge clk);
    tick();
    read_check("t6_pos", ADDR_POS_LO, 16'h0000);
    read_check("t6_status", ADDR_STATUS, 16'h0001);
    read_check("t6_errcnt", ADDR_ERRCNT, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
